// File: rtl/aes_pkg.sv
// Shared definitions for the S-box lookup controller: FSM states, table
// depth and the read latency of the S-box SRAM.
package aes_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        IDLE   = 2'd1,
        LOOKUP = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int SBOX_DEPTH  = 256;
    localparam int SRAM_RD_LAT = 1;

    function automatic logic is_last_entry(input logic [7:0] cnt);
        return (cnt == 8'(SBOX_DEPTH - 1));
    endfunction

endpackage

// File: rtl/sbox_lookup_ctrl.sv
// Loads a 256-entry S-box into an external SRAM, then substitutes every byte
// of a state block through it with one pipelined read per cycle.
module sbox_lookup_ctrl
    import aes_pkg::*;
#(
    parameter int NBYTES     = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_valid,
    input  logic [ADDR_WIDTH-1:0]        ld_data,
    output logic                         ld_ready,
    input  logic                         reload,
    output logic                         table_ok,
    input  logic                         in_valid,
    input  logic [ADDR_WIDTH*NBYTES-1:0] in_state,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [ADDR_WIDTH*NBYTES-1:0] out_state,
    input  logic                         out_ready,
    output logic                         csb0,
    output logic [ADDR_WIDTH-1:0]        addr0,
    output logic [ADDR_WIDTH-1:0]        din0,
    output logic                         csb1,
    output logic [ADDR_WIDTH-1:0]        addr1,
    input  logic [ADDR_WIDTH-1:0]        dout1
);

    localparam int IW = $clog2(NBYTES + 1);
    localparam int OW = IW + 3;

    state_t                         state_r;
    state_t                         state_s;
    logic [7:0]                     ld_cnt_r;
    logic [IW-1:0]                  idx_r;
    logic [ADDR_WIDTH*NBYTES-1:0]   in_state_r;
    logic                           last_rd_s;
    logic [OW-1:0]                  rd_off_s;
    logic [OW-1:0]                  cap_off_s;

    assign last_rd_s = (idx_r == IW'(NBYTES));
    assign rd_off_s  = {idx_r, 3'b000};
    // Read k returns its data SRAM_RD_LAT cycles later, so capture lags issue.
    assign cap_off_s = {idx_r - IW'(SRAM_RD_LAT), 3'b000};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and the combinational SRAM/handshake outputs.
    always_comb begin
        state_s  = state_r;
        ld_ready = 1'b0;
        in_ready = 1'b0;
        csb0     = 1'b1;
        addr0    = '0;
        din0     = '0;
        csb1     = 1'b1;
        addr1    = '0;
        case (state_r)
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    csb0  = 1'b0;
                    addr0 = ADDR_WIDTH'(ld_cnt_r);
                    din0  = ld_data;
                    if (is_last_entry(ld_cnt_r)) begin
                        state_s = IDLE;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            IDLE: begin
                in_ready = table_ok;
                // A same-cycle handshake wins over reload.
                if (in_valid && table_ok) begin
                    state_s = LOOKUP;
                end else if (reload) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (last_rd_s) begin
                    state_s = HOLD;
                end else begin
                    csb1    = 1'b0;
                    addr1   = in_state_r[rd_off_s +: ADDR_WIDTH];
                    state_s = LOOKUP;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = LOAD;
            end
        endcase
    end

    // Load counter, table status, captured input block and result assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt_r   <= 8'd0;
            idx_r      <= '0;
            in_state_r <= '0;
            out_state  <= '0;
            table_ok   <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (ld_valid) begin
                        if (is_last_entry(ld_cnt_r)) begin
                            ld_cnt_r <= 8'd0;
                            table_ok <= 1'b1;
                        end else begin
                            ld_cnt_r <= ld_cnt_r + 8'd1;
                        end
                    end
                end
                IDLE: begin
                    if (in_valid && table_ok) begin
                        in_state_r <= in_state;
                        idx_r      <= '0;
                    end else if (reload) begin
                        table_ok <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (idx_r >= IW'(SRAM_RD_LAT)) begin
                        out_state[cap_off_s +: ADDR_WIDTH] <= dout1;
                    end
                    if (last_rd_s) begin
                        out_valid <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_lookup_ctrl.sv
// Directed/randomized bench for sbox_lookup_ctrl with a behavioural SRAM and
// an S-box computed from GF(2^8) inversion plus the AES affine map.
module tb_sbox_lookup_ctrl;

    localparam int NB = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            ld_valid;
    logic [7:0]      ld_data;
    logic            ld_ready;
    logic            reload;
    logic            table_ok;
    logic            in_valid;
    logic [8*NB-1:0] in_state;
    logic            in_ready;
    logic            out_valid;
    logic [8*NB-1:0] out_state;
    logic            out_ready;
    logic            csb0;
    logic [7:0]      addr0;
    logic [7:0]      din0;
    logic            csb1;
    logic [7:0]      addr1;
    logic [7:0]      dout1;

    always #5 clk = ~clk;

    sbox_lookup_ctrl #(.NBYTES(NB), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .reload(reload), .table_ok(table_ok),
        .in_valid(in_valid), .in_state(in_state), .in_ready(in_ready),
        .out_valid(out_valid), .out_state(out_state), .out_ready(out_ready),
        .csb0(csb0), .addr0(addr0), .din0(din0),
        .csb1(csb1), .addr1(addr1), .dout1(dout1)
    );

    logic [7:0] mem    [256];
    logic [7:0] sbox_t [256];
    int total = 0;
    int bad   = 0;
    int wr_cnt = 0, rd_cnt = 0, addr_err = 0, idle_wr = 0;
    logic [7:0] exp_addr = 8'd0;

    // Single-clock SRAM: synchronous write port, one-cycle-latency read port,
    // plus write-sequence bookkeeping.
    always @(posedge clk) begin
        if (!csb0) begin
            mem[addr0] <= din0;
            if (addr0 !== exp_addr) addr_err <= addr_err + 1;
            if (!ld_valid) idle_wr <= idle_wr + 1;
            exp_addr <= exp_addr + 8'd1;
            wr_cnt   <= wr_cnt + 1;
        end
        if (!csb1) begin
            dout1  <= mem[addr1];
            rd_cnt <= rd_cnt + 1;
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'd0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] v);
        logic [7:0]  inv;
        logic [15:0] d;
        inv = 8'd0;
        for (int y = 1; y < 256; y++)
            if (gmul(v, 8'(y)) == 8'd1) inv = 8'(y);
        d = {inv, inv};
        return inv ^ d[14 -: 8] ^ d[13 -: 8] ^ d[12 -: 8] ^ d[11 -: 8] ^ 8'h63;
    endfunction

    function automatic logic [8*NB-1:0] model(input logic [8*NB-1:0] v);
        logic [8*NB-1:0] r;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = sbox_t[v[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_table(input bit gaps);
        int w0, e0, i0, mm;
        w0 = wr_cnt; e0 = addr_err; i0 = idle_wr;
        for (int i = 0; i < 256; i++) begin
            if (gaps) begin
                ld_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            if (i == 255) chk("table_ok_before_last", table_ok, 1'b0);
            ld_valid = 1'b1;
            ld_data  = sbox_t[i];
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        chk("table_ok_after_load", table_ok, 1'b1);
        chk("ld_ready_after_load", ld_ready, 1'b0);
        chk("write_count", wr_cnt - w0, 256);
        chk("write_addr_order", addr_err - e0, 0);
        chk("write_on_idle", idle_wr - i0, 0);
        mm = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== sbox_t[i]) mm++;
        chk("sram_content", mm, 0);
    endtask

    task automatic do_lookup(input logic [8*NB-1:0] v, input int hold, input bit rl_both,
                             input bit rl_mid, output logic [8*NB-1:0] res);
        int n, rd0, rd1;
        bit stable;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("in_ready_wait", in_ready, 1'b1);
        rd0 = rd_cnt;
        in_valid = 1'b1; in_state = v; reload = rl_both;
        @(posedge clk); #1;
        in_valid = 1'b0; in_state = '0; reload = rl_mid;
        n = 1;
        while (!out_valid && n < 100) begin @(posedge clk); #1; reload = 1'b0; n++; end
        chk("latency", n, NB + 2);
        chk("lookup_reads", rd_cnt - rd0, NB);
        chk("table_ok_in_lookup", table_ok, 1'b1);
        res = out_state;
        rd1 = rd_cnt;
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (out_state !== res || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("hold_stable", stable, 1'b1);
        chk("hold_no_reads", rd_cnt - rd1, 0);
        out_ready = 1'b1; reload = rl_mid;
        @(posedge clk); #1;
        out_ready = 1'b0; reload = 1'b0;
        chk("out_valid_drop", out_valid, 1'b0);
        chk("in_ready_back", in_ready, 1'b1);
    endtask

    initial begin
        logic [8*NB-1:0] v, res;
        int rd0;
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        rst = 1'b1; ld_valid = 1'b0; ld_data = 8'd0; reload = 1'b0;
        in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ld_ready", ld_ready, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_state", out_state, '0);
        chk("rst_table_ok", table_ok, 1'b0);
        chk("rst_csb", {csb0, csb1}, 2'b11);
        chk("rst_addr_din", {addr0, din0, addr1}, 24'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        load_table(1'b0);
        do_lookup('0, 0, 1'b0, 1'b0, res);
        chk("lookup_zero", res, 128'h63636363636363636363636363636363);

        v = 128'hffeeddccbbaa99887766554433221100;
        do_lookup(v, 10, 1'b0, 1'b0, res);
        chk("lookup_vector", res, 128'h1628c14beaaceec4f533fc1bc3938263);

        for (int t = 0; t < 8; t++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            do_lookup(v, $urandom_range(0, 5), 1'b0, t[0], res);
            chk("lookup_random", res, model(v));
        end

        v = {$urandom, $urandom, $urandom, $urandom};
        do_lookup(v, 1, 1'b1, 1'b0, res);
        chk("reload_with_handshake", res, model(v));
        chk("table_ok_kept", table_ok, 1'b1);

        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        chk("reload_table_ok", table_ok, 1'b0);
        chk("reload_ld_ready", ld_ready, 1'b1);
        chk("reload_in_ready", in_ready, 1'b0);
        rd0 = rd_cnt;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("in_valid_ignored_in_load", rd_cnt - rd0, 0);

        load_table(1'b1);
        v = {$urandom, $urandom, $urandom, $urandom};
        do_lookup(v, 2, 1'b0, 1'b1, res);
        chk("lookup_after_reload", res, model(v));

        // Reset in the middle of a lookup, while byte 7 is being read.
        v = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1; in_state = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("byte7_read", {csb1, addr1}, {1'b0, v[63:56]});
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_ld_ready", ld_ready, 1'b1);
        chk("midrst_table_ok", table_ok, 1'b0);
        chk("midrst_csb1", csb1, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        load_table(1'b1);
        v = {$urandom, $urandom, $urandom, $urandom};
        do_lookup(v, 3, 1'b0, 1'b0, res);
        chk("lookup_after_rst", res, model(v));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
